mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Round-robin arbiter and sequencer for the shared external SRAM data bus, which is reached through the Bidir port block. It grants one requester at a time (CPU, video fetch, etc.) and drives address and strobes with a configurable wait-state count. It controls bus direction so the port is released (input) except while a write is being driven. A one-cycle release at the end of every access gives bus turnaround.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 8, memory data width
WAIT_STATES, 1, extra cycles per access beyond the first (0..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
req  in  NUM_REQ  per-requester access request, level
wr  in  NUM_REQ  per-requester direction: 1 = write, 0 = read
addr  in  NUM_REQ*ADDR_WIDTH  flat; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  in  NUM_REQ*DATA_WIDTH  flat write data, same packing
ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  out  DATA_WIDTH  read data; valid in the ack cycle and held until the next read capture
busy  out  1  high in any state other than IDLE
mem_addr  out  ADDR_WIDTH  external address
mem_wdata  out  DATA_WIDTH  to Bidir "out" side
mem_rdata  in  DATA_WIDTH  from Bidir "in" side
mem_sel_in  out  1  Bidir direction: 1 = port is input (released), 0 = drive mem_wdata
mem_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low SRAM strobes

Behaviour:
- Reset values: state IDLE, ack=0, rdata=0, busy=0, mem_addr=0, mem_wdata=0, mem_sel_in=1, mem_ce_n=mem_oe_n=mem_we_n=1, round-robin pointer=0, wait counter=0.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: if any req bit is set, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ. On the grant edge, latch the id, wr, addr and wdata; load the counter with WAIT_STATES; go to ACCESS. If no req is set, stay in IDLE.
- ACCESS, all cycles: mem_ce_n=0 and mem_addr = latched address.
  - Read: mem_oe_n=0, mem_sel_in=1.
  - Write: mem_we_n=0, mem_sel_in=0, mem_wdata = latched data.
  - Counter decrements each cycle. On the cycle where it is 0: a read captures mem_rdata into rdata, then the block goes to DONE.
  - ACCESS lasts exactly WAIT_STATES+1 cycles.
- DONE, exactly 1 cycle:
  - ack[granted]=1.
  - All strobes high, mem_sel_in=1 (turnaround).
  - Pointer = granted+1 mod NUM_REQ.
  - Next state IDLE.
- Latency: req sampled high in IDLE at edge n gives ack high in cycle n+WAIT_STATES+2. Peak throughput is one access per WAIT_STATES+3 cycles.
- Requesters must drop req, or present a new request, in the cycle after ack. A req still high in IDLE is a new request.
- Changes to req, addr, wdata or wr after the grant have no effect on the transaction in flight.
- When several requests are pending, round-robin makes each requester wait at most NUM_REQ-1 accesses.
- Invariant: mem_sel_in=0 only while mem_we_n=0, so mem_we_n and mem_oe_n are never both low.
- reset is asserted mid-access: on the next edge all outputs take their reset values, no ack is issued, and the transaction is dropped.
- Out-of-range WAIT_STATES is not supported. The counter is 4 bits.

Decomposition:
- Shared include file mem_bus_defs.vh holds the state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the counter width constant (4).
- One sub-module, rr_priority_picker. Inputs: req vector and pointer. Outputs: one-hot grant and binary id. It is purely combinational and parameterized by NUM_REQ.
- The FSM, latches and strobes stay in mem_bus_arbiter.

Test Plan:
1. Reset, then req=2'b01, wr=0, addr0=16'h1234, mem_rdata=8'hA5, WAIT_STATES=1. Expect mem_addr=1234 and oe_n low for 2 cycles, then ack=2'b01 three cycles after the grant edge, with rdata=A5 and mem_sel_in high throughout.
2. Write from requester 1: addr1=16'h00FF, wdata1=8'h3C. Expect mem_sel_in=0, mem_we_n=0 and mem_wdata=3C for exactly 2 cycles, then a DONE cycle with mem_sel_in=1 and ack=2'b10.
3. Both req held high continuously for 4 accesses. Expect grants alternating 0,1,0,1, with ack pulses spaced 4 cycles apart.
4. Grant to requester 0, then change addr0 to 16'hBEEF during ACCESS. Expect mem_addr to stay at the originally latched 1234.
5. Assert reset during the second ACCESS cycle of a write. Expect mem_we_n=1, mem_sel_in=1 and ack=0 on the next edge, busy=0, and the next grant going to requester 0.
6. WAIT_STATES=0 build with one read. Expect a 1-cycle ACCESS, ack 2 cycles after the grant edge, and the invariant that mem_we_n and mem_oe_n are never both low checked on every cycle of every test.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the external SRAM bus arbiter: FSM encoding, wait counter width,
// and the id width helper used by the arbiter and its round-robin picker.
package mem_bus_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Zero latency; no flow control, grant is all-zero when req is empty.
module rr_priority_picker
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);

  logic [ID_W-1:0] scan_idx;
  logic            found;

  always_comb begin
    grant    = '0;
    id       = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        id              = scan_idx;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin SRAM bus sequencer: ack arrives WAIT_STATES+2 edges after the grant edge,
// one access per WAIT_STATES+3 cycles; requesters hold req until ack, a DONE cycle turns the bus around.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               ack,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             mem_sel_in,
  output logic                             mem_ce_n,
  output logic                             mem_oe_n,
  output logic                             mem_we_n
);

  localparam int ID_W = id_width(NUM_REQ);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      gnt_id;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic                 gnt_wr;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [ID_W-1:0]      pick_id;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_oh),
    .id    (pick_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      gnt_id     <= '0;
      gnt_oh     <= '0;
      gnt_wr     <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_sel_in <= 1'b1;
      mem_ce_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            // Strobes are set up here so they are already valid in the first ACCESS cycle.
            state    <= ST_ACCESS;
            busy     <= 1'b1;
            gnt_id   <= pick_id;
            gnt_oh   <= pick_oh;
            gnt_wr   <= wr[pick_id];
            cnt      <= CNT_W'(WAIT_STATES);
            mem_addr <= addr_arr[pick_id];
            mem_ce_n <= 1'b0;
            if (wr[pick_id]) begin
              mem_we_n   <= 1'b0;
              mem_sel_in <= 1'b0;
              mem_wdata  <= wdata_arr[pick_id];
            end else begin
              mem_oe_n <= 1'b0;
            end
          end
        end

        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!gnt_wr) begin
              rdata <= mem_rdata;
            end
            mem_ce_n   <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            mem_sel_in <= 1'b1;
            ack        <= gnt_oh;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_DONE: begin
          ack   <= '0;
          busy  <= 1'b0;
          ptr   <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level round-robin/memory model,
// plus a WAIT_STATES=0 instance for the single-cycle access case.
module tb_mem_bus_arbiter;

  localparam int NR = 2;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance (WAIT_STATES=1)
  logic [1:0]  req, wr;
  logic [15:0] a_addr  [2];
  logic [7:0]  a_wdata [2];
  logic [31:0] addr_flat;
  logic [15:0] wdata_flat;
  logic [1:0]  ack;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic        busy, mem_sel_in, mem_ce_n, mem_oe_n, mem_we_n;

  assign addr_flat  = {a_addr[1], a_addr[0]};
  assign wdata_flat = {a_wdata[1], a_wdata[0]};

  mem_bus_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr_flat), .wdata(wdata_flat),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_sel_in(mem_sel_in), .mem_ce_n(mem_ce_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  // zero-wait-state instance
  logic [1:0]  z_req, z_wr, z_ack;
  logic [31:0] z_addr;
  logic [15:0] z_wdata;
  logic [7:0]  z_rdata, z_mem_wdata, z_mem_rdata;
  logic [15:0] z_mem_addr;
  logic        z_busy, z_sel_in, z_ce_n, z_oe_n, z_we_n;

  mem_bus_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(z_req), .wr(z_wr), .addr(z_addr), .wdata(z_wdata),
    .ack(z_ack), .rdata(z_rdata), .busy(z_busy), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .mem_sel_in(z_sel_in), .mem_ce_n(z_ce_n),
    .mem_oe_n(z_oe_n), .mem_we_n(z_we_n)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  // SRAM environment and the bench's own expected memory contents
  logic [7:0] sram    [0:65535];
  logic [7:0] exp_mem [0:65535];

  always @(posedge clk)
    if (!mem_ce_n && !mem_we_n) sram[mem_addr] <= mem_wdata;
  assign mem_rdata   = (!mem_ce_n && !mem_oe_n) ? sram[mem_addr] : 8'h00;
  assign z_mem_rdata = (!z_ce_n && !z_oe_n) ? init_byte(z_mem_addr) : 8'h00;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int m_ptr = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // bus-safety invariants, every cycle, both instances
  always @(negedge clk) begin
    if (!reset) begin
      check("oe_we_exclusive", {31'd0, mem_oe_n | mem_we_n}, 32'd1);
      check("drive_only_on_write", {31'd0, !mem_sel_in && mem_we_n}, 32'd0);
      check("z_oe_we_exclusive", {31'd0, z_oe_n | z_we_n}, 32'd1);
      check("z_drive_only_on_write", {31'd0, !z_sel_in && z_we_n}, 32'd0);
    end
  end

  function automatic int rr_pick(input logic [1:0] p, input int ptr);
    for (int k = 0; k < NR; k++)
      if (p[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  // Requesters in mask assert req; each access is predicted by round robin over the
  // currently asserted set. Non-hold requesters drop req after their ack; in hold mode
  // every requester keeps requesting until n_total accesses have completed.
  task automatic run_batch(input logic [1:0] mask, input bit perturb, input bit hold, input int n_total);
    logic [15:0] s_addr [2];
    logic [7:0]  s_wdata [2];
    logic        s_wr [2];
    logic [1:0]  pend;
    int exp_id, n_acc, t, t0, last_ack, served;
    bit bad_addr, bad_strb;
    for (int i = 0; i < NR; i++) begin
      s_addr[i] = a_addr[i]; s_wdata[i] = a_wdata[i]; s_wr[i] = wr[i];
    end
    pend = mask;
    served = 0;
    last_ack = 0;
    @(negedge clk);
    req = mask;
    t0 = cyc;
    while (served < n_total) begin
      exp_id = rr_pick(pend, m_ptr);
      t = 0;
      while (mem_ce_n && t < 20) begin @(negedge clk); t++; end
      if (mem_ce_n) begin
        check("access_timeout", 32'd0, 32'd1);
        req = '0;
        return;
      end
      n_acc = 0; bad_addr = 0; bad_strb = 0;
      while (!mem_ce_n && n_acc < 20) begin
        if (mem_addr !== s_addr[exp_id]) bad_addr = 1;
        if (s_wr[exp_id]) begin
          if ({mem_oe_n, mem_we_n, mem_sel_in} !== 3'b100 || mem_wdata !== s_wdata[exp_id]) bad_strb = 1;
        end else begin
          if ({mem_oe_n, mem_we_n, mem_sel_in} !== 3'b011) bad_strb = 1;
        end
        if (!busy || ack !== 2'b00) bad_strb = 1;
        if (perturb && n_acc == 0) begin
          a_addr[exp_id]  = 16'hBEEF;
          a_wdata[exp_id] = ~s_wdata[exp_id];
          wr[exp_id]      = ~s_wr[exp_id];
        end
        n_acc++;
        @(negedge clk);
      end
      check("access_len", n_acc, WS + 1);
      check("addr_held", {31'd0, bad_addr}, 32'd0);
      check("access_strobes", {31'd0, bad_strb}, 32'd0);
      check("ack_id", {30'd0, ack}, 32'd1 << exp_id);
      check("done_released", {29'd0, mem_sel_in, mem_oe_n, mem_we_n}, 32'd7);
      check("done_busy", {31'd0, busy}, 32'd1);
      if (served == 0) check("ack_latency", cyc - t0, WS + 2);
      else             check("ack_spacing", cyc - last_ack, WS + 3);
      last_ack = cyc;
      if (s_wr[exp_id]) exp_mem[s_addr[exp_id]] = s_wdata[exp_id];
      else              check("rdata", {24'd0, rdata}, {24'd0, exp_mem[s_addr[exp_id]]});
      m_ptr = (exp_id + 1) % NR;
      served++;
      if (!hold) begin
        pend[exp_id] = 1'b0;
        req[exp_id]  = 1'b0;
      end
      if (served == n_total) req = '0;
    end
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ack", {30'd0, ack}, 32'd0);
  endtask

  task automatic set_req(input int i, input logic w, input logic [15:0] a, input logic [7:0] d);
    wr[i] = w; a_addr[i] = a; a_wdata[i] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    logic [1:0] mask;
    bit hold, perturb;
    int n, nacc;
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = init_byte(16'(i));
      exp_mem[i] = init_byte(16'(i));
    end
    reset = 1'b1;
    req = '0; wr = '0;
    a_addr[0] = '0; a_addr[1] = '0; a_wdata[0] = '0; a_wdata[1] = '0;
    z_req = '0; z_wr = '0; z_addr = '0; z_wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_strobes", {28'd0, mem_sel_in, mem_ce_n, mem_oe_n, mem_we_n}, 32'hF);
    reset = 1'b0;
    m_ptr = 0;

    // read from requester 0
    set_req(0, 1'b0, 16'h1234, 8'h00);
    run_batch(2'b01, 1'b0, 1'b0, 1);
    check("t1_rdata_a5", {24'd0, rdata}, 32'hA5);

    // write from requester 1, then read it back
    set_req(1, 1'b1, 16'h00FF, 8'h3C);
    run_batch(2'b10, 1'b0, 1'b0, 1);
    check("t2_mem_wdata", {24'd0, mem_wdata}, 32'h3C);
    set_req(0, 1'b0, 16'h00FF, 8'h00);
    run_batch(2'b01, 1'b0, 1'b0, 1);
    check("t2_readback", {24'd0, rdata}, 32'h3C);

    // both held for 4 accesses: alternation and 4-cycle spacing
    set_req(0, 1'b0, 16'h0010, 8'h00);
    set_req(1, 1'b0, 16'h0020, 8'h00);
    run_batch(2'b11, 1'b0, 1'b1, 4);

    // inputs changed after grant must not affect the access
    set_req(0, 1'b0, 16'h1234, 8'h11);
    run_batch(2'b01, 1'b1, 1'b0, 1);

    // reset during the second ACCESS cycle of a write
    set_req(1, 1'b1, 16'hF0F0, 8'h77);
    @(negedge clk);
    req = 2'b10;
    n = 0;
    while (mem_ce_n && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    check("t5_in_access", {31'd0, mem_ce_n}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    req = '0;
    check("t5_we_n", {31'd0, mem_we_n}, 32'd1);
    check("t5_sel_in", {31'd0, mem_sel_in}, 32'd1);
    check("t5_ack", {30'd0, ack}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    m_ptr = 0;
    set_req(0, 1'b0, 16'h0030, 8'h00);
    set_req(1, 1'b0, 16'h0031, 8'h00);
    run_batch(2'b11, 1'b0, 1'b0, 2);

    // randomized batches
    for (int b = 0; b < 30; b++) begin
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < NR; i++)
        set_req(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 8'($urandom));
      hold    = ($urandom_range(0, 3) == 0);
      perturb = !hold && ($urandom_range(0, 1) == 1);
      n       = hold ? $urandom_range(2, 5) : ((mask == 2'b11) ? 2 : 1);
      run_batch(mask, perturb, hold, n);
    end

    // zero-wait-state instance: single read
    @(negedge clk);
    z_wr = 2'b00;
    z_addr = {16'h0000, 16'h4321};
    z_req = 2'b01;
    n = 0; nacc = 0;
    while (z_ack == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
      if (!z_ce_n) nacc++;
    end
    z_req = '0;
    check("ws0_latency", n, 2);
    check("ws0_access_len", nacc, 1);
    check("ws0_ack", {30'd0, z_ack}, 32'd1);
    check("ws0_rdata", {24'd0, z_rdata}, {24'd0, init_byte(16'h4321)});
    @(negedge clk);
    check("ws0_idle", {31'd0, z_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
